// File: rtl/vector_vrf_port_sequencer_if.sv
// Request/grant bundle between the vector issue logic and the VRF port
// sequencer, together with the slice VRF control fields the sequencer drives.
interface vector_vrf_port_sequencer_if #(
    parameter int NUM_UNITS = 5,
    parameter int ADDR_W    = 5,
    parameter int SRC_W     = 3
);
    logic [NUM_UNITS-1:0]        rd_valid;
    logic [NUM_UNITS-1:0]        rd_two;
    logic [NUM_UNITS*ADDR_W-1:0] rd_addr_a;
    logic [NUM_UNITS*ADDR_W-1:0] rd_addr_b;
    logic [NUM_UNITS-1:0]        rd_ready;
    logic [NUM_UNITS-1:0]        wb_valid;
    logic [NUM_UNITS*ADDR_W-1:0] wb_addr;
    logic [NUM_UNITS-1:0]        wb_ready;
    logic                        vrf_en;
    logic                        vrf_we;
    logic [ADDR_W-1:0]           vrf_addr;
    logic [SRC_W-1:0]            vrf_src_unit;
    logic [NUM_UNITS*2-1:0]      reg_in_en;

    // Issue side: raises requests, observes grants and slice controls.
    modport master (
        output rd_valid, rd_two, rd_addr_a, rd_addr_b, wb_valid, wb_addr,
        input  rd_ready, wb_ready, vrf_en, vrf_we, vrf_addr, vrf_src_unit, reg_in_en
    );

    // Sequencer side.
    modport slave (
        input  rd_valid, rd_two, rd_addr_a, rd_addr_b, wb_valid, wb_addr,
        output rd_ready, wb_ready, vrf_en, vrf_we, vrf_addr, vrf_src_unit, reg_in_en
    );
endinterface

// File: rtl/vector_vrf_port_sequencer.sv
// Single-port VRF scheduler for one vector slice. Each cycle grants one
// access: a write-back (fixed priority, lowest unit first) or an operand read
// (round-robin). Two-operand reads occupy two consecutive cycles atomically.
// The unit input-register enable is pulsed one cycle after each read.
module vector_vrf_port_sequencer #(
    parameter int VRF_SIZE  = 32,
    parameter int NUM_UNITS = 5,
    parameter int ADDR_W    = $clog2(VRF_SIZE),
    parameter int SRC_W     = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    vector_vrf_port_sequencer_if.slave        bus
);
    typedef enum logic {IDLE, SECOND_OP} state_e;

    state_e                 state_q, state_d;
    logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]       pend_unit_q, pend_unit_d;
    logic [ADDR_W-1:0]      pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0]      last_addr_q, last_addr_d;
    logic [SRC_W-1:0]       last_src_q, last_src_d;
    logic [NUM_UNITS*2-1:0] reg_in_en_q, reg_in_en_d;

    logic [ADDR_W-1:0]      rd_a [NUM_UNITS];
    logic [ADDR_W-1:0]      rd_b [NUM_UNITS];
    logic [ADDR_W-1:0]      wb_a [NUM_UNITS];
    logic                   wb_any;
    logic [SRC_W-1:0]       wb_sel;
    logic                   rd_any;
    logic [SRC_W-1:0]       rd_sel;
    logic                   rd_is_two;
    logic [SRC_W-1:0]       rr_idx;

    // Arbitration: lowest-index write-back, round-robin read after rr_ptr.
    always_comb begin
        wb_any = 1'b0;
        wb_sel = '0;
        rd_any = 1'b0;
        rd_sel = '0;
        rr_idx = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            rd_a[u] = bus.rd_addr_a[u*ADDR_W +: ADDR_W];
            rd_b[u] = bus.rd_addr_b[u*ADDR_W +: ADDR_W];
            wb_a[u] = bus.wb_addr[u*ADDR_W +: ADDR_W];
        end
        for (int u = NUM_UNITS - 1; u >= 0; u--) begin
            if (bus.wb_valid[u]) begin
                wb_any = 1'b1;
                wb_sel = SRC_W'(u);
            end
        end
        for (int k = 1; k <= NUM_UNITS; k++) begin
            rr_idx = SRC_W'((int'(rr_ptr_q) + k) % NUM_UNITS);
            if (!rd_any && bus.rd_valid[rr_idx]) begin
                rd_any = 1'b1;
                rd_sel = rr_idx;
            end
        end
        // Only VALU (0) and PERMUTE (last) have a second operand.
        rd_is_two = bus.rd_two[rd_sel] &&
                    ((rd_sel == '0) || (rd_sel == SRC_W'(NUM_UNITS - 1)));
    end

    // State register; reset abandons any half-finished two-operand read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= SRC_W'(NUM_UNITS - 1);
            pend_unit_q <= '0;
            pend_addr_q <= '0;
            last_addr_q <= '0;
            last_src_q  <= '0;
            reg_in_en_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            pend_unit_q <= pend_unit_d;
            pend_addr_q <= pend_addr_d;
            last_addr_q <= last_addr_d;
            last_src_q  <= last_src_d;
            reg_in_en_q <= reg_in_en_d;
        end
    end

    // Next state: pointer update, B-operand capture and the one-hot latch pulse.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        pend_unit_d = pend_unit_q;
        pend_addr_d = pend_addr_q;
        last_addr_d = last_addr_q;
        last_src_d  = last_src_q;
        reg_in_en_d = '0;
        case (state_q)
            IDLE: begin
                if (wb_any) begin
                    last_addr_d = wb_a[wb_sel];
                    last_src_d  = wb_sel;
                end else if (rd_any) begin
                    rr_ptr_d                     = rd_sel;
                    last_addr_d                  = rd_a[rd_sel];
                    last_src_d                   = rd_sel;
                    reg_in_en_d[{rd_sel, 1'b0}]  = 1'b1;
                    if (rd_is_two) begin
                        state_d     = SECOND_OP;
                        pend_unit_d = rd_sel;
                        pend_addr_d = rd_b[rd_sel];
                    end
                end
            end
            SECOND_OP: begin
                state_d                          = IDLE;
                last_addr_d                      = pend_addr_q;
                last_src_d                       = pend_unit_q;
                reg_in_en_d[{pend_unit_q, 1'b1}] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: VRF controls and ready strobes; all forced low while in reset.
    always_comb begin
        bus.vrf_en       = 1'b0;
        bus.vrf_we       = 1'b0;
        bus.vrf_addr     = last_addr_q;
        bus.vrf_src_unit = last_src_q;
        bus.rd_ready     = '0;
        bus.wb_ready     = '0;
        if (!reset) begin
            bus.vrf_addr     = '0;
            bus.vrf_src_unit = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wb_any) begin
                        bus.vrf_en           = 1'b1;
                        bus.vrf_we           = 1'b1;
                        bus.vrf_addr         = wb_a[wb_sel];
                        bus.vrf_src_unit     = wb_sel;
                        bus.wb_ready[wb_sel] = 1'b1;
                    end else if (rd_any) begin
                        bus.vrf_en       = 1'b1;
                        bus.vrf_addr     = rd_a[rd_sel];
                        bus.vrf_src_unit = rd_sel;
                        if (!rd_is_two) begin
                            bus.rd_ready[rd_sel] = 1'b1;
                        end
                    end
                end
                SECOND_OP: begin
                    bus.vrf_en                = 1'b1;
                    bus.vrf_addr              = pend_addr_q;
                    bus.vrf_src_unit          = pend_unit_q;
                    bus.rd_ready[pend_unit_q] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.reg_in_en = reg_in_en_q;
endmodule

// File: tb/tb_vector_vrf_port_sequencer.sv
// Bench for the VRF port sequencer: a table of directed cycles followed by
// randomized traffic compared against a queue-free behavioural model.
module tb_vector_vrf_port_sequencer;
    localparam int N  = 5;
    localparam int AW = 5;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_mis;

    vector_vrf_port_sequencer_if #(.NUM_UNITS(N), .ADDR_W(AW), .SRC_W(3)) bus ();

    vector_vrf_port_sequencer dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [4:0]  rdv, two, wbv;
        logic [24:0] aa, ab, wa;
        logic        en, we;
        logic [4:0]  addr;
        logic [2:0]  src;
        logic [4:0]  rdr, wbr;
        logic [9:0]  rie;
    } vec_t;

    vec_t tbl[$];

    // model state
    int         m_pend;
    int         m_pend_b;
    int         m_last;
    logic [9:0] m_pulse;

    function automatic logic [24:0] slot(int u, int a);
        logic [24:0] v;
        v = 25'(a) << (u * AW);
        return v;
    endfunction

    function automatic int field(logic [24:0] v, int u);
        return int'((v >> (u * AW)) & 25'h1f);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [4:0] rdv, two, wbv,
                       input logic [24:0] aa, ab, wa,
                       input logic en, we, input int addr, src,
                       input logic [4:0] rdr, wbr, input logic [9:0] rie);
        vec_t v;
        v.rst_n = r; v.rdv = rdv; v.two = two; v.wbv = wbv;
        v.aa = aa; v.ab = ab; v.wa = wa;
        v.en = en; v.we = we; v.addr = 5'(addr); v.src = 3'(src);
        v.rdr = rdr; v.wbr = wbr; v.rie = rie;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst_n         = v.rst_n;
        bus.rd_valid  = v.rdv;
        bus.rd_two    = v.two;
        bus.wb_valid  = v.wbv;
        bus.rd_addr_a = v.aa;
        bus.rd_addr_b = v.ab;
        bus.wb_addr   = v.wa;
    endtask

    // Higher-level reference: one VRF access per cycle, write-backs first,
    // reads round-robin after the last read winner, a pending B read is atomic.
    task automatic model_check(output logic [4:0] e_rdr, output logic [4:0] e_wbr);
        logic       e_en, e_we;
        int         e_addr, e_src, u;
        logic [9:0] nxt;
        e_en = 0; e_we = 0; e_addr = 0; e_src = 0; e_rdr = '0; e_wbr = '0; nxt = '0; u = -1;
        if (!rst_n) begin
            m_pend = -1;
            m_last = N - 1;
        end else if (m_pend >= 0) begin
            e_en = 1; e_addr = m_pend_b; e_src = m_pend;
            e_rdr[m_pend] = 1'b1;
            nxt[2*m_pend+1] = 1'b1;
            m_pend = -1;
        end else if (bus.wb_valid != 0) begin
            for (int i = N - 1; i >= 0; i--) if (bus.wb_valid[i]) u = i;
            e_en = 1; e_we = 1; e_addr = field(bus.wb_addr, u); e_src = u;
            e_wbr[u] = 1'b1;
        end else if (bus.rd_valid != 0) begin
            for (int k = N; k >= 1; k--) if (bus.rd_valid[(m_last + k) % N]) u = (m_last + k) % N;
            e_en = 1; e_addr = field(bus.rd_addr_a, u); e_src = u;
            m_last = u;
            nxt[2*u] = 1'b1;
            if (bus.rd_two[u] && (u == 0 || u == N - 1)) begin
                m_pend = u;
                m_pend_b = field(bus.rd_addr_b, u);
            end else begin
                e_rdr[u] = 1'b1;
            end
        end
        chk("rnd_vrf_en", 32'(bus.vrf_en), 32'(e_en));
        chk("rnd_vrf_we", 32'(bus.vrf_we), 32'(e_we));
        chk("rnd_rd_ready", 32'(bus.rd_ready), 32'(e_rdr));
        chk("rnd_wb_ready", 32'(bus.wb_ready), 32'(e_wbr));
        chk("rnd_reg_in_en", 32'(bus.reg_in_en), 32'(m_pulse));
        if (e_en) begin
            chk("rnd_vrf_addr", 32'(bus.vrf_addr), 32'(e_addr));
            chk("rnd_vrf_src_unit", 32'(bus.vrf_src_unit), 32'(e_src));
        end
        m_pulse = nxt;
    endtask

    initial begin
        logic [24:0] A;
        logic [4:0]  er, ew;
        n_vec = 0; n_mis = 0;
        m_pend = -1; m_pend_b = 0; m_last = N - 1; m_pulse = '0;
        rst_n = 1'b0;
        bus.rd_valid = '0; bus.rd_two = '0; bus.wb_valid = '0;
        bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.wb_addr = '0;
        repeat (2) @(posedge clk);
        #1;

        A = slot(0, 10) | slot(1, 11) | slot(2, 12) | slot(3, 13) | slot(4, 14);
        // reset held with everything requesting
        repeat (3) add(0, 5'h1f, 0, 5'h1f, A, 0, 0,  0, 0, 0, 0, 5'h00, 5'h00, 10'h000);
        // round-robin 0,1,2,3,4 then wrap to 0
        add(1, 5'h1f, 0, 0, A, 0, 0,  1, 0, 10, 0, 5'h01, 0, 10'h000);
        add(1, 5'h1f, 0, 0, A, 0, 0,  1, 0, 11, 1, 5'h02, 0, 10'h001);
        add(1, 5'h1f, 0, 0, A, 0, 0,  1, 0, 12, 2, 5'h04, 0, 10'h004);
        add(1, 5'h1f, 0, 0, A, 0, 0,  1, 0, 13, 3, 5'h08, 0, 10'h010);
        add(1, 5'h1f, 0, 0, A, 0, 0,  1, 0, 14, 4, 5'h10, 0, 10'h040);
        add(1, 5'h1f, 0, 0, A, 0, 0,  1, 0, 10, 0, 5'h01, 0, 10'h100);
        add(1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 10'h001);
        // single read on CMP
        add(1, 5'h04, 0, 0, slot(2, 7), 0, 0,  1, 0, 7, 2, 5'h04, 0, 10'h000);
        add(1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 10'h010);
        // two-operand VALU read with a write-back arriving mid-sequence
        add(1, 5'h01, 5'h01, 0,     slot(0, 3), slot(0, 9), 0,           1, 0, 3, 0, 0, 0, 10'h000);
        add(1, 5'h01, 5'h01, 5'h02, slot(0, 3), slot(0, 9), slot(1, 20), 1, 0, 9, 0, 5'h01, 0, 10'h001);
        add(1, 0, 0, 5'h02, 0, 0, slot(1, 20),  1, 1, 20, 1, 0, 5'h02, 10'h002);
        add(1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 10'h000);
        // write-back priority over a pending read
        add(1, 5'h01, 0, 5'h18, slot(0, 3), 0, slot(3, 5) | slot(4, 6), 1, 1, 5, 3, 0, 5'h08, 10'h000);
        add(1, 5'h01, 0, 5'h10, slot(0, 3), 0, slot(4, 6),              1, 1, 6, 4, 0, 5'h10, 10'h000);
        add(1, 5'h01, 0, 0,     slot(0, 3), 0, 0,                       1, 0, 3, 0, 5'h01, 0, 10'h000);
        add(1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 10'h001);
        // same unit, same address: write first, read afterwards
        add(1, 5'h04, 0, 5'h04, slot(2, 8), 0, slot(2, 8), 1, 1, 8, 2, 0, 5'h04, 10'h000);
        add(1, 5'h04, 0, 0,     slot(2, 8), 0, 0,          1, 0, 8, 2, 5'h04, 0, 10'h000);
        add(1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 10'h010);
        // reset during the B cycle of a PERMUTE read; re-served from A
        add(1, 5'h10, 5'h10, 0, slot(4, 17), slot(4, 18), 0, 1, 0, 17, 4, 0, 0, 10'h000);
        add(0, 5'h10, 5'h10, 0, slot(4, 17), slot(4, 18), 0, 0, 0, 0, 0, 0, 0, 10'h100);
        add(1, 5'h10, 5'h10, 0, slot(4, 17), slot(4, 18), 0, 1, 0, 17, 4, 0, 0, 10'h000);
        add(1, 5'h10, 5'h10, 0, slot(4, 17), slot(4, 18), 0, 1, 0, 18, 4, 5'h10, 0, 10'h100);
        add(1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 10'h200);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("t%0d_vrf_en", i), 32'(bus.vrf_en), 32'(tbl[i].en));
            chk($sformatf("t%0d_vrf_we", i), 32'(bus.vrf_we), 32'(tbl[i].we));
            chk($sformatf("t%0d_rd_ready", i), 32'(bus.rd_ready), 32'(tbl[i].rdr));
            chk($sformatf("t%0d_wb_ready", i), 32'(bus.wb_ready), 32'(tbl[i].wbr));
            chk($sformatf("t%0d_reg_in_en", i), 32'(bus.reg_in_en), 32'(tbl[i].rie));
            if (tbl[i].en) begin
                chk($sformatf("t%0d_vrf_addr", i), 32'(bus.vrf_addr), 32'(tbl[i].addr));
                chk($sformatf("t%0d_vrf_src_unit", i), 32'(bus.vrf_src_unit), 32'(tbl[i].src));
            end
            @(posedge clk);
            #1;
        end

        // randomized traffic obeying the hold-until-ready handshake
        bus.rd_valid = '0; bus.wb_valid = '0; bus.rd_two = '0;
        for (int c = 0; c < 3000; c++) begin
            rst_n = (c < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
            @(negedge clk);
            model_check(er, ew);
            @(posedge clk);
            #1;
            for (int u = 0; u < N; u++) begin
                if (er[u]) bus.rd_valid[u] = 1'b0;
                if (ew[u]) bus.wb_valid[u] = 1'b0;
                if (!bus.rd_valid[u] && $urandom_range(0, 99) < 35) begin
                    bus.rd_valid[u] = 1'b1;
                    bus.rd_two[u]   = 1'($urandom_range(0, 1));
                    bus.rd_addr_a[u*AW +: AW] = 5'($urandom_range(0, 31));
                    bus.rd_addr_b[u*AW +: AW] = 5'($urandom_range(0, 31));
                end
                if (!bus.wb_valid[u] && $urandom_range(0, 99) < 15) begin
                    bus.wb_valid[u] = 1'b1;
                    bus.wb_addr[u*AW +: AW] = 5'($urandom_range(0, 31));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
